// File: rtl/de1_soc_morse.sv
// de1_soc_morse: DE1-SoC Morse-code key decoder (key press -> dot/dash -> letter on HEX0).
//   CLOCK_50     in   50 MHz clock, all state on the rising edge
//   SW[9]        in   synchronous active-high reset; SW[8] = correct (mirrored to LEDR[6])
//   KEY[0]       in   Morse key, active-low, asynchronous
//   HEX0..HEX5   out  7-segment {g,f,e,d,c,b,a}, active-low; HEX0 = current letter
//   LEDR         out  {3'b0, correct, divided clock bit, 1'b0, reset, 1'b0, dot, dash}
// Optional feature macro: AUTO_CLEAR_EN (idle gap ends a letter and scrolls it into HEX1..HEX5).
module de1_soc_morse #(
    parameter int WHICH_CLOCK = 0,
    parameter int DASH_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic [9:0] SW,
    input  logic [3:0] KEY,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);
    localparam logic [5:0] START = 6'b000001;
    localparam logic [5:0] ERR   = 6'b111111;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAR   = 7'b0111111;
    localparam int CW = $clog2(DASH_CYCLES + 1);
    logic          rst;
    logic [31:0]   clk_cnt;
    logic          sync1, sync2, pressed;
    logic [CW-1:0] count;
    logic          dot, dash;
    logic [5:0]    state;
    logic [6:0]    glyph;
    logic          gap_hit;
    logic          unused_ok;
    assign rst     = SW[9];
    assign pressed = ~sync2;
    always_ff @(posedge CLOCK_50) begin
        if (rst) clk_cnt <= '0;
        else     clk_cnt <= clk_cnt + 32'd1;
    end
    // count != 0 marks that the previous cycle was pressed, so it doubles as the release detector.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            count <= '0;
            dot   <= 1'b0;
            dash  <= 1'b0;
        end else begin
            sync1 <= KEY[0];
            sync2 <= sync1;
            count <= pressed ? (count >= CW'(DASH_CYCLES) ? count : count + 1'b1) : '0;
            dot   <= !pressed && count != '0 && count < CW'(DASH_CYCLES);
            dash  <= !pressed && count >= CW'(DASH_CYCLES);
        end
    end
    // Sentinel-shift decoder: a 4-symbol code has the sentinel in bit 4, so the next symbol errors.
    always_ff @(posedge CLOCK_50) begin
        if (rst)              state <= START;
        else if (gap_hit)     state <= START;
        else if (dot || dash) state <= (state[5] || state[4]) ? ERR : {state[4:0], dash};
    end
    always_comb begin
        case (state)
            6'b000001: glyph = BLANK;
            6'b000010: glyph = 7'b0000110; // E
            6'b000011: glyph = 7'b0000111; // T
            6'b000100: glyph = 7'b1111001; // I
            6'b000101: glyph = 7'b0001000; // A
            6'b000110: glyph = 7'b0101011; // N
            6'b000111: glyph = 7'b1001000; // M
            6'b001000: glyph = 7'b0010010; // S
            6'b001001: glyph = 7'b1000001; // U
            6'b001010: glyph = 7'b0101111; // R
            6'b001011: glyph = 7'b1010101; // W
            6'b001100: glyph = 7'b0100001; // D
            6'b001101: glyph = 7'b0001010; // K
            6'b001110: glyph = 7'b1000010; // G
            6'b001111: glyph = 7'b1000000; // O
            6'b010000: glyph = 7'b0001001; // H
            6'b010001: glyph = 7'b1100011; // V
            6'b010010: glyph = 7'b0001110; // F
            6'b010100: glyph = 7'b1000111; // L
            6'b010110: glyph = 7'b0001100; // P
            6'b010111: glyph = 7'b1100001; // J
            6'b011000: glyph = 7'b0000011; // B
            6'b011001: glyph = 7'b0110110; // X
            6'b011010: glyph = 7'b1000110; // C
            6'b011011: glyph = 7'b0010001; // Y
            6'b011100: glyph = 7'b0100100; // Z
            6'b011101: glyph = 7'b0011000; // Q
            default:   glyph = BAR;
        endcase
    end
    assign HEX0 = glyph;
`ifdef AUTO_CLEAR_EN
    localparam int GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0]  gap;
    logic [4:0][6:0] hist;
    // Fires on the GAP_CYCLES-th consecutive idle cycle with a letter in progress.
    assign gap_hit = !pressed && state != START && gap == GW'(GAP_CYCLES - 1);
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            gap  <= '0;
            hist <= {5{BLANK}};
        end else begin
            gap <= (pressed || state == START || gap_hit) ? '0 : gap + 1'b1;
            if (gap_hit) hist <= {hist[3:0], glyph};
        end
    end
    assign {HEX5, HEX4, HEX3, HEX2, HEX1} = hist;
`else
    assign gap_hit = 1'b0;
    assign {HEX5, HEX4, HEX3, HEX2, HEX1} = {5{BLANK}};
`endif
    assign LEDR = {3'b000, SW[8], clk_cnt[WHICH_CLOCK], 1'b0, rst, 1'b0, dot, dash};
    assign unused_ok = ^{SW[7:0], KEY[3:1], clk_cnt, 32'(GAP_CYCLES)};
endmodule

// File: tb/tb_de1_soc_morse.sv
// tb_de1_soc_morse: randomized self-checking bench for de1_soc_morse against a string-table Morse model.
module tb_de1_soc_morse;
    localparam int DASH  = 4;
    localparam int GAP   = 8;
    localparam int WHICH = 1;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAR   = 7'b0111111;
    logic       clk = 1'b0;
    logic [9:0] SW;
    logic [3:0] KEY;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] div_m;
    bit sym_q[$];
    logic [6:0] font [string];

    de1_soc_morse #(.WHICH_CLOCK(WHICH), .DASH_CYCLES(DASH), .GAP_CYCLES(GAP)) dut (
        .CLOCK_50(clk), .SW(SW), .KEY(KEY),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .LEDR(LEDR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) div_m <= SW[9] ? 32'd0 : div_m + 32'd1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_glyph();
        string code = "";
        if (sym_q.size() == 0) return BLANK;
        if (sym_q.size() > 4) return BAR;
        foreach (sym_q[i]) begin
            if (sym_q[i]) code = {code, "-"};
            else          code = {code, "."};
        end
        return font.exists(code) ? font[code] : BAR;
    endfunction

    function automatic logic [5:0] exp_state();
        int st = 1;
        if (sym_q.size() > 4) return 6'h3F;
        foreach (sym_q[i]) st = st * 2 + int'(sym_q[i]);
        return 6'(st);
    endfunction

    task automatic do_reset();
        SW[9]  = 1'b1;
        KEY[0] = 1'b1;
        @(negedge clk);
        check("rst_ledr3", 64'(LEDR[3]), 64'd1);
        check("rst_pulse", 64'(LEDR[1:0]), 64'd0);
        check("rst_hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'({6{BLANK}}));
        SW[9] = 1'b0;
        sym_q.delete();
    endtask

    // Watches the five negedges after a release; m is the number of pressed cycles seen by the DUT.
    task automatic observe(input int m);
        int at = 0, ndot = 0, ndash = 0, both = 0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (LEDR[1] || LEDR[0]) at = n;
            ndot  += int'(LEDR[1]);
            ndash += int'(LEDR[0]);
            both  += int'(LEDR[1] && LEDR[0]);
        end
        sym_q.push_back(m >= DASH);
        check("pulse_at", 64'(at), 64'd3);
        check("dot_cnt", 64'(ndot), 64'(m < DASH));
        check("dash_cnt", 64'(ndash), 64'(m >= DASH));
        check("dot_and_dash", 64'(both), 64'd0);
        check("hex0", 64'(HEX0), 64'(exp_glyph()));
        check("state", 64'(dut.state), 64'(exp_state()));
    endtask

    task automatic symbol(input int m);
        KEY[0] = 1'b0;
        repeat (m) @(negedge clk);
        KEY[0] = 1'b1;
        observe(m);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        int pulses;
        font["."]    = 7'b0000110; font["-"]    = 7'b0000111;
        font[".."]   = 7'b1111001; font[".-"]   = 7'b0001000;
        font["-."]   = 7'b0101011; font["--"]   = 7'b1001000;
        font["..."]  = 7'b0010010; font["..-"]  = 7'b1000001;
        font[".-."]  = 7'b0101111; font[".--"]  = 7'b1010101;
        font["-.."]  = 7'b0100001; font["-.-"]  = 7'b0001010;
        font["--."]  = 7'b1000010; font["---"]  = 7'b1000000;
        font["...."] = 7'b0001001; font["...-"] = 7'b1100011;
        font["..-."] = 7'b0001110; font[".-.."] = 7'b1000111;
        font[".--."] = 7'b0001100; font[".---"] = 7'b1100001;
        font["-..."] = 7'b0000011; font["-..-"] = 7'b0110110;
        font["-.-."] = 7'b1000110; font["-.--"] = 7'b0010001;
        font["--.."] = 7'b0100100; font["--.-"] = 7'b0011000;
        SW  = 10'h200;
        KEY = 4'hF;
        do_reset();
        repeat (6) @(negedge clk);
        check("idle_hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'({6{BLANK}}));
        check("idle_pulse", 64'(LEDR[1:0]), 64'd0);
        check("idle_state", 64'(dut.state), 64'd1);
        symbol(1);
        do_reset();
        repeat (3) symbol(10);
        do_reset();
        repeat (4) symbol(1);
        symbol(1);
        symbol(10);
        do_reset();
        symbol(DASH - 1);
        symbol(DASH);
        for (int i = 0; i < 8; i++) begin
            SW[8] = 1'($urandom);
            @(negedge clk);
            check("ledr6_correct", 64'(LEDR[6]), 64'(SW[8]));
            check("ledr5_div", 64'(LEDR[5]), 64'(div_m[WHICH]));
            check("ledr_zero", 64'(LEDR & 10'b1110010100), 64'd0);
        end
        for (int t = 0; t < 8; t++) begin
            do_reset();
            repeat ($urandom_range(1, 6)) symbol($urandom_range(1, 7));
            check("hex1_5_blank", 64'({HEX5, HEX4, HEX3, HEX2, HEX1}), 64'({5{BLANK}}));
        end
        do_reset();
        pulses = 0;
        KEY[0] = 1'b0;
        repeat (6) @(negedge clk);
        SW[9] = 1'b1;
        @(negedge clk);
        KEY[0] = 1'b1;
        repeat (2) @(negedge clk);
        SW[9] = 1'b0;
        sym_q.delete();
        repeat (6) begin
            @(negedge clk);
            pulses += int'(LEDR[1] || LEDR[0]);
        end
        check("rstmid_nopulse", 64'(pulses), 64'd0);
        check("rstmid_state", 64'(dut.state), 64'd1);
        check("rstmid_hex0", 64'(HEX0), 64'(BLANK));
        KEY[0] = 1'b0;
        repeat (3) @(negedge clk);
        SW[9] = 1'b1;
        @(negedge clk);
        SW[9] = 1'b0;
        sym_q.delete();
        repeat (2) @(negedge clk);
        KEY[0] = 1'b1;
        observe(2);
        do_reset();
        symbol(1);
        repeat (GAP + 6) @(negedge clk);
`ifdef AUTO_CLEAR_EN
        check("gap_hex1", 64'(HEX1), 64'(font["."]));
        check("gap_hex0", 64'(HEX0), 64'(BLANK));
        check("gap_state", 64'(dut.state), 64'd1);
        check("gap_hex2_5", 64'({HEX5, HEX4, HEX3, HEX2}), 64'({4{BLANK}}));
`else
        check("hold_hex1", 64'(HEX1), 64'(BLANK));
        check("hold_hex0", 64'(HEX0), 64'(font["."]));
        check("hold_state", 64'(dut.state), 64'd2);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
